// File: rtl/aidan_mcnay_iter_divider_if.sv
// Request/response stream bundle for the iterative divider.
// Request side: dividend/divisor with val/rdy. Response side: quotient/remainder with val/rdy.
interface aidan_mcnay_iter_divider_if #(
  parameter int nbits = 16
);
  logic             istream_val;
  logic             istream_rdy;
  logic [nbits-1:0] istream_dividend;
  logic [nbits-1:0] istream_divisor;
  logic             ostream_val;
  logic             ostream_rdy;
  logic [nbits-1:0] ostream_quotient;
  logic [nbits-1:0] ostream_remainder;

  // Producer of requests and consumer of results
  modport master (
    output istream_val, istream_dividend, istream_divisor, ostream_rdy,
    input  istream_rdy, ostream_val, ostream_quotient, ostream_remainder
  );

  // The divider itself
  modport slave (
    input  istream_val, istream_dividend, istream_divisor, ostream_rdy,
    output istream_rdy, ostream_val, ostream_quotient, ostream_remainder
  );
endinterface

// File: rtl/aidan_mcnay_iter_divider.sv
// Iterative unsigned restoring divider, one quotient bit per cycle.
// Fixed latency of nbits CALC cycles regardless of operands; divide by zero
// falls out of the algorithm as quotient = all ones, remainder = dividend.
module aidan_mcnay_iter_divider #(
  parameter int nbits = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  aidan_mcnay_iter_divider_if.slave   dif
);

  localparam int CW = (nbits > 1) ? $clog2(nbits) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [nbits-1:0] dvd_q, dvd_d;    // dividend shift register, MSB feeds the remainder
  logic [nbits-1:0] dvs_q, dvs_d;    // latched divisor
  logic [nbits-1:0] rem_q, rem_d;    // partial remainder
  logic [nbits-1:0] quot_q, quot_d;  // quotient shift register
  logic [CW-1:0]    cnt_q, cnt_d;    // remaining CALC cycles minus one

  // The shifted remainder needs nbits+1 bits so the compare cannot overflow.
  // The stored remainder only needs nbits: after the restore step it is
  // always strictly below the divisor, or equal to the shifted value when
  // the divisor is zero, whose top bit is then dropped exactly as the
  // algorithm does on the next shift.
  logic [nbits:0]   rem_shift;
  logic             rem_ge;

  // State and datapath registers; reset discards any in-flight operation
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath step: accept in IDLE, one restoring step per CALC cycle, hold in DONE
  always_comb begin
    state_d   = state_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    cnt_d     = cnt_q;
    rem_shift = {rem_q, dvd_q[nbits-1]};
    rem_ge    = (rem_shift >= {1'b0, dvs_q});

    unique case (state_q)
      IDLE: begin
        if (dif.istream_val) begin
          state_d = CALC;
          dvd_d   = dif.istream_dividend;
          dvs_d   = dif.istream_divisor;
          rem_d   = '0;
          quot_d  = '0;
          cnt_d   = CW'(nbits - 1);
        end
      end
      CALC: begin
        dvd_d  = dvd_q << 1;
        rem_d  = rem_ge ? nbits'(rem_shift - {1'b0, dvs_q}) : nbits'(rem_shift);
        quot_d = {quot_q[nbits-2:0], rem_ge};
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DONE: begin
        if (dif.ostream_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore handshake outputs; results come straight from registers
  always_comb begin
    dif.istream_rdy       = (state_q == IDLE);
    dif.ostream_val       = (state_q == DONE);
    dif.ostream_quotient  = quot_q;
    dif.ostream_remainder = rem_q;
  end

endmodule
